// File: rtl/fp_sqrt_iter.sv
// Iterative IEEE-754-style square root: one root bit per cycle by restoring recurrence,
// then round-to-nearest-even. Subnormal inputs are treated as zero of the same sign.
module fp_sqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic                   out_invalid,
    output logic                   out_inexact
);

    localparam int N     = MAN_W + 2;
    localparam int REM_W = MAN_W + 4;
    localparam int X_W   = 2 * N;
    localparam int CNT_W = $clog2(N);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W+1:0] BIAS_X   = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W+MAN_W:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W+MAN_W:0] PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds valid and data stable until that edge, ready never waits on valid.

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t state, state_nxt;

    logic [X_W-1:0]   x_q;
    logic [REM_W-1:0] rem_q;
    logic [N-1:0]     root_q;
    logic [CNT_W-1:0] cnt_q;
    logic [EXP_W-1:0] res_exp_q;

    // operand decode
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    logic             exp_max, exp_zero, man_zero;
    logic             is_nan, is_special, accept;

    assign in_sign  = in_data[EXP_W+MAN_W];
    assign in_exp   = in_data[MAN_W +: EXP_W];
    assign in_man   = in_data[MAN_W-1:0];
    assign exp_max  = &in_exp;
    assign exp_zero = ~|in_exp;
    assign man_zero = ~|in_man;
    assign is_nan     = exp_max & ~man_zero;
    assign is_special = exp_max | exp_zero | in_sign;
    assign accept     = in_valid & (state == IDLE);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    logic [EXP_W+MAN_W:0] special_data;
    logic                 special_invalid;

    always_comb begin
        special_data    = PINF;
        special_invalid = 1'b0;
        if (is_nan) begin
            special_data    = QNAN;
            special_invalid = 1'b1;
        end else if (exp_zero) begin
            special_data = {in_sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (in_sign) begin
            special_data    = QNAN;
            special_invalid = 1'b1;
        end
    end

    // Result exponent is floor(e/2)+bias; an odd e moves one power of two into the radicand.
    logic signed [EXP_W+1:0] e_unb, e_half;
    logic [EXP_W+1:0]        e_sum;
    logic [EXP_W-1:0]        exp_calc;
    logic [MAN_W+1:0]        rad;
    logic                    unused_bits;

    assign e_unb       = $signed({2'b00, in_exp} - BIAS_X);
    assign e_half      = e_unb >>> 1;
    assign e_sum       = $unsigned(e_half) + BIAS_X;
    assign exp_calc    = e_sum[EXP_W-1:0];
    assign unused_bits = ^e_sum[EXP_W+1:EXP_W];
    assign rad         = e_unb[0] ? {1'b1, in_man, 1'b0} : {1'b0, 1'b1, in_man};

    // one restoring step: bring down two radicand bits, try subtracting 4*root+1
    logic [REM_W-1:0] rem_sh, trial, rem_nxt;
    logic             take;
    logic [N-1:0]     root_nxt;

    assign rem_sh   = {rem_q[REM_W-3:0], x_q[X_W-1 -: 2]};
    assign trial    = {root_q, 2'b01};
    assign take     = (rem_sh >= trial);
    assign rem_nxt  = take ? (rem_sh - trial) : rem_sh;
    assign root_nxt = {root_q[N-2:0], take};

    // rounding: root_q holds integer bit, MAN_W fraction bits and a guard bit
    logic             guard, lsb, sticky, round_up, carry;
    logic [MAN_W+1:0] mant_sum;
    logic [MAN_W-1:0] res_man;
    logic [EXP_W-1:0] res_exp;

    assign guard    = root_q[0];
    assign lsb      = root_q[1];
    assign sticky   = |rem_q;
    assign round_up = guard & (sticky | lsb);
    assign mant_sum = {1'b0, root_q[N-1:1]} + {{(MAN_W+1){1'b0}}, round_up};
    assign carry    = mant_sum[MAN_W+1];
    assign res_man  = carry ? {MAN_W{1'b0}} : mant_sum[MAN_W-1:0];
    assign res_exp  = res_exp_q + {{(EXP_W-1){1'b0}}, carry};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = is_special ? DONE : CALC;
            CALC:  if (cnt_q == '0) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q         <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            res_exp_q   <= '0;
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_special) begin
                            out_data    <= special_data;
                            out_invalid <= special_invalid;
                            out_inexact <= 1'b0;
                        end else begin
                            x_q       <= {rad, {N{1'b0}}};
                            rem_q     <= '0;
                            root_q    <= '0;
                            cnt_q     <= CNT_LAST;
                            res_exp_q <= exp_calc;
                        end
                    end
                end
                CALC: begin
                    x_q    <= {x_q[X_W-3:0], 2'b00};
                    rem_q  <= rem_nxt;
                    root_q <= root_nxt;
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
                end
                ROUND: begin
                    out_data    <= {1'b0, res_exp, res_man};
                    out_invalid <= 1'b0;
                    out_inexact <= guard | sticky;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Directed and randomized bench for fp_sqrt_iter at default widths and at EXP_W=5, MAN_W=10.
module tb_fp_sqrt_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_invalid, out_inexact;
  logic [31:0] in_data, out_data;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_out_invalid, h_out_inexact;
  logic [15:0] h_in_data, h_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_sqrt_iter dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_invalid(out_invalid), .out_inexact(out_inexact)
  );

  fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_data(h_out_data),
    .out_invalid(h_out_invalid), .out_inexact(h_out_inexact)
  );

  // reference: bit 63 = invalid, bit 62 = inexact, low bits = result word
  function automatic logic [63:0] ref_sqrt(input logic [63:0] op, input int ew, input int mw);
    logic [63:0] man, expo, sgn, all1, bias, qnan, rad, x, r, t, res;
    int e, odd, re;
    logic inx, up;
    man  = op & ((64'd1 << mw) - 64'd1);
    expo = (op >> mw) & ((64'd1 << ew) - 64'd1);
    sgn  = (op >> (ew + mw)) & 64'd1;
    all1 = (64'd1 << ew) - 64'd1;
    bias = (64'd1 << (ew - 1)) - 64'd1;
    qnan = (all1 << mw) | (64'd1 << (mw - 1));
    if (expo == all1 && man != 64'd0) return (64'd1 << 63) | qnan;
    if (expo == 64'd0) return sgn << (ew + mw);
    if (sgn != 64'd0) return (64'd1 << 63) | qnan;
    if (expo == all1) return all1 << mw;
    e   = int'(expo) - int'(bias);
    odd = e & 1;
    rad = ((64'd1 << mw) | man) << odd;
    x   = rad << mw;
    r   = 64'd0;
    for (int b = mw + 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    inx = (r * r != x);
    up  = ((64'd2 * r + 64'd1) * (64'd2 * r + 64'd1) < 64'd4 * x);
    r   = r + {63'd0, up};
    re  = (e - odd) / 2 + int'(bias);
    if ((r >> (mw + 1)) != 64'd0) begin
      re = re + 1;
      r  = 64'd0;
    end
    res = (64'(re) << mw) | (r & ((64'd1 << mw) - 64'd1));
    res[62] = inx;
    return res;
  endfunction

  function automatic logic [63:0] rand_op(input int ew, input int mw);
    logic [63:0] man, expo, sgn, all1;
    int k;
    all1 = (64'd1 << ew) - 64'd1;
    man  = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    sgn  = 64'd0;
    k    = $urandom_range(0, 9);
    if (k == 0) begin
      expo = ($urandom_range(0, 1) == 1) ? all1 : 64'd0;
      sgn  = 64'($urandom_range(0, 1));
    end else begin
      expo = 64'($urandom_range(1, int'(all1) - 1));
      if (k == 1) sgn = 64'd1;
    end
    return (sgn << (ew + mw)) | (expo << mw) | man;
  endfunction

  task automatic do_op(input logic [31:0] op, output logic [31:0] data, output logic inv,
                       output logic inx, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    in_data  = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    data = out_data;
    inv  = out_invalid;
    inx  = out_inexact;
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL timeout op=%h: out_valid still %b after %0d cycles, required 1", op, out_valid, lat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 8;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    if (out_invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got %b want 0", out_invalid); end
    if (out_inexact !== 1'b0) begin errors++; $display("FAIL reset_inexact got %b want 0", out_inexact); end
    if (h_in_ready !== 1'b1) begin errors++; $display("FAIL reset_h_in_ready got %b want 1", h_in_ready); end
    if (h_out_valid !== 1'b0) begin errors++; $display("FAIL reset_h_out_valid got %b want 0", h_out_valid); end
    if (h_out_data !== 16'h0) begin errors++; $display("FAIL reset_h_out_data got %h want 0", h_out_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_normal;
    logic [31:0] ops [5] = '{32'h40800000, 32'h41100000, 32'h40000000, 32'h3F800000, 32'h3E800000};
    logic [31:0] exps[5] = '{32'h40000000, 32'h40400000, 32'h3FB504F3, 32'h3F800000, 32'h3F000000};
    logic        inxs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] d;
    logic        inv, inx;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], d, inv, inx, lat);
      checks += 5;
      if (d !== exps[i]) begin errors++; $display("FAIL normal_data op=%h got %h want %h", ops[i], d, exps[i]); end
      if (inx !== inxs[i]) begin errors++; $display("FAIL normal_inexact op=%h got %b want %b", ops[i], inx, inxs[i]); end
      if (inv !== 1'b0) begin errors++; $display("FAIL normal_invalid op=%h got %b want 0", ops[i], inv); end
      if (lat != 27) begin errors++; $display("FAIL normal_latency op=%h got %0d want 27", ops[i], lat); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL normal_release op=%h in_ready got %b want 1", ops[i], in_ready); end
    end
  endtask

  task automatic test_special;
    logic [31:0] ops [8] = '{32'hBF800000, 32'h7F800000, 32'h80000000, 32'h00000001,
                             32'h7F812345, 32'hFF800000, 32'h00000000, 32'h807FFFFF};
    logic [31:0] exps[8] = '{32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000000,
                             32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h80000000};
    logic        invs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] d;
    logic        inv, inx;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], d, inv, inx, lat);
      checks += 4;
      if (d !== exps[i]) begin errors++; $display("FAIL special_data op=%h got %h want %h", ops[i], d, exps[i]); end
      if (inv !== invs[i]) begin errors++; $display("FAIL special_invalid op=%h got %b want %b", ops[i], inv, invs[i]); end
      if (inx !== 1'b0) begin errors++; $display("FAIL special_inexact op=%h got %b want 0", ops[i], inx); end
      if (lat != 1) begin errors++; $display("FAIL special_latency op=%h got %0d want 1", ops[i], lat); end
    end
  endtask

  task automatic test_hold;
    int w = 0;
    in_valid = 1'b1;
    in_data  = 32'h41100000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && w < 60) begin
      @(posedge clk); #1; w++;
    end
    for (int c = 0; c < 5; c++) begin
      checks += 5;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cycle %0d got %b want 1", c, out_valid); end
      if (out_data !== 32'h40400000) begin errors++; $display("FAIL hold_data cycle %0d got %h want 40400000", c, out_data); end
      if (out_invalid !== 1'b0) begin errors++; $display("FAIL hold_invalid cycle %0d got %b want 0", c, out_invalid); end
      if (out_inexact !== 1'b0) begin errors++; $display("FAIL hold_inexact cycle %0d got %b want 0", c, out_inexact); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cycle %0d got %b want 0", c, in_ready); end
      @(posedge clk); #1;
    end
    // offer a new operand in the release cycle: it must not be taken on that edge
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h40800000;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got %b want 0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_busy_ignore;
    int w = 0;
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    @(posedge clk); #1;
    in_data = 32'h41100000;
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
    end
    in_valid = 1'b0;
    while (!out_valid && w < 60) begin
      @(posedge clk); #1; w++;
    end
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL busy_timeout out_valid got %b want 1", out_valid); end
    if (out_data !== 32'h3FB504F3) begin errors++; $display("FAIL busy_data got %h want 3fb504f3", out_data); end
    if (out_inexact !== 1'b1) begin errors++; $display("FAIL busy_inexact got %b want 1", out_inexact); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        inv, inx;
    int          lat;
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks += 7;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    if (out_data !== 32'h0) begin errors++; $display("FAIL midrst_out_data got %h want 0", out_data); end
    if (out_invalid !== 1'b0) begin errors++; $display("FAIL midrst_invalid got %b want 0", out_invalid); end
    if (out_inexact !== 1'b0) begin errors++; $display("FAIL midrst_inexact got %b want 0", out_inexact); end
    if (dut.cnt_q !== '0) begin errors++; $display("FAIL midrst_counter got %0d want 0", dut.cnt_q); end
    if (dut.rem_q !== '0) begin errors++; $display("FAIL midrst_remainder got %h want 0", dut.rem_q); end
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL postrst_in_ready got %b want 1", in_ready); end
    do_op(32'h40800000, d, inv, inx, lat);
    checks += 3;
    if (d !== 32'h40000000) begin errors++; $display("FAIL postrst_data got %h want 40000000", d); end
    if (inx !== 1'b0) begin errors++; $display("FAIL postrst_inexact got %b want 0", inx); end
    if (lat != 27) begin errors++; $display("FAIL postrst_latency got %0d want 27", lat); end
  endtask

  task automatic test_back_to_back;
    logic [33:0] exp_q[$];
    logic [33:0] obs, want;
    logic [63:0] m, r;
    logic [31:0] op;
    logic        hs_in, hs_out;
    int          got = 0;
    int          cyc = 0;
    r  = rand_op(8, 23);
    op = r[31:0];
    in_valid = 1'b1;
    in_data  = op;
    while (got < 40 && cyc < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      hs_in  = in_valid & in_ready;
      hs_out = out_valid & out_ready;
      obs    = {out_invalid, out_inexact, out_data};
      @(posedge clk); #1;
      cyc++;
      if (hs_in) begin
        m = ref_sqrt({32'd0, op}, 8, 23);
        exp_q.push_back({m[63], m[62], m[31:0]});
        r  = rand_op(8, 23);
        op = r[31:0];
        in_data = op;
      end
      if (hs_out) begin
        checks++;
        got++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_0000_0000;
        if (obs !== want) begin
          errors++;
          $display("FAIL b2b32 result %0d got {inv,inx,data}=%h want %h", got, obs, want);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got < 40) begin errors++; $display("FAIL b2b32_timeout got %0d results want 40", got); end
    apply_reset();
  endtask

  task automatic test_back_to_back_half;
    logic [17:0] exp_q[$];
    logic [17:0] obs, want;
    logic [63:0] m, r;
    logic [15:0] op;
    logic        hs_in, hs_out;
    int          got = 0;
    int          cyc = 0;
    r  = rand_op(5, 10);
    op = r[15:0];
    h_in_valid = 1'b1;
    h_in_data  = op;
    while (got < 60 && cyc < 5000) begin
      h_out_ready = 1'($urandom_range(0, 1));
      hs_in  = h_in_valid & h_in_ready;
      hs_out = h_out_valid & h_out_ready;
      obs    = {h_out_invalid, h_out_inexact, h_out_data};
      @(posedge clk); #1;
      cyc++;
      if (hs_in) begin
        m = ref_sqrt({48'd0, op}, 5, 10);
        exp_q.push_back({m[63], m[62], m[15:0]});
        r  = rand_op(5, 10);
        op = r[15:0];
        h_in_data = op;
      end
      if (hs_out) begin
        checks++;
        got++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3_0000;
        if (obs !== want) begin
          errors++;
          $display("FAIL b2b16 result %0d got {inv,inx,data}=%h want %h", got, obs, want);
        end
      end
    end
    h_in_valid  = 1'b0;
    h_out_ready = 1'b0;
    checks++;
    if (got < 60) begin errors++; $display("FAIL b2b16_timeout got %0d results want 60", got); end
    apply_reset();
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    out_ready   = 1'b0;
    h_in_valid  = 1'b0;
    h_in_data   = 16'h0;
    h_out_ready = 1'b0;
    test_reset();
    test_normal();
    test_special();
    test_hold();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_back_to_back_half();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_iter.md
FP_SQRT_ITER -- requirements
Module: fp_sqrt_iter

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning the exponent field width (EXP_W >= 3).
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning the stored mantissa field width (MAN_W >= 4); W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  operand present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 The block SHALL have port in_data  input  W  IEEE-754-style operand {sign, exp, man}.
REQ-008 The block SHALL have port out_valid  output  1  result present.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 The block SHALL have port out_data  output  W  square-root result.
REQ-011 The block SHALL have port out_invalid  output  1  the result is NaN because the input was NaN or negative non-zero.
REQ-012 The block SHALL have port out_inexact  output  1  the rounded result differs from the exact root.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC, ROUND and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 An input handshake SHALL occur when in_valid=1 and in_ready=1 at a rising edge (t); in_data SHALL be captured at t and SHALL NOT be sampled afterwards.
REQ-015 Special cases SHALL go IDLE->DONE with out_valid=1 from cycle t+1, with these results:
- NaN input -> quiet NaN {0, all-ones exp, 1 followed by zeros}, invalid=1.
- Negative non-zero input, including -inf -> the same quiet NaN, invalid=1.
- +inf -> +inf.
- +0 -> +0.
- -0 -> -0.
- Subnormal input -> flushed to zero of the same sign, giving +0 or -0.
- inexact=0 for every special case.
REQ-016 For a normal positive input, the block SHALL compute e = exp - bias, where bias = 2^(EXP_W-1)-1.
- Radicand = {1, man}, shifted left one place when e is odd.
- Result exponent = floor(e/2) + bias, computed with an arithmetic shift.
REQ-017 CALC SHALL run a restoring digit-by-digit recurrence that produces one root bit per cycle for N = MAN_W+2 cycles: 1 integer bit, MAN_W fraction bits and 1 guard bit.
- An iteration counter SHALL count N-1 down to 0.
- The remainder register SHALL be MAN_W+4 bits wide.
REQ-018 ROUND SHALL take 1 cycle and apply round-to-nearest-even.
- sticky = (final remainder != 0).
- Round up when guard & (sticky | lsb).
- inexact = guard | sticky.
- A mantissa carry-out SHALL increment the exponent and zero the mantissa.
REQ-019 Normal-path timing: CALC SHALL occupy cycles t+1..t+N, ROUND cycle t+N+1, and out_valid SHALL rise at t+N+2 (t+27 at default parameters).
REQ-020 In DONE, out_data, out_invalid and out_inexact SHALL be held stable while out_ready=0.
REQ-021 On out_ready=1 in DONE, the block SHALL go to IDLE on that edge; in_ready SHALL become 1 the following cycle, and there SHALL be no same-cycle re-accept.
REQ-022 in_valid asserted while in_ready=0 SHALL be ignored and SHALL NOT corrupt an operation in flight.
REQ-023 Results SHALL never overflow or underflow the exponent range, and the sign of every non-NaN, non-zero result SHALL be 0.

Reset
REQ-024 When rst_n=0 at a rising edge, the block SHALL enter IDLE regardless of state and SHALL discard any operation in progress, including one in CALC or DONE.
REQ-025 Reset values SHALL be: in_ready=1, out_valid=0, out_data=0, out_invalid=0, out_inexact=0, iteration counter=0, remainder=0.
REQ-026 After rst_n returns to 1, the first operand SHALL be acceptable in the first cycle.

Verification
REQ-027 The bench SHALL cover these exact results at default parameters:
- 0x40800000 (4.0) -> 0x40000000, inexact=0, out_valid exactly at t+27.
- 0x41100000 (9.0) -> 0x40400000.
- 0x40000000 (2.0) -> 0x3FB504F3, inexact=1.
REQ-028 The bench SHALL cover these special inputs, each with out_valid at t+1:
- 0xBF800000 -> 0x7FC00000, invalid=1.
- 0x7F800000 -> 0x7F800000.
- 0x80000000 -> 0x80000000.
- 0x00000001 -> 0x00000000.
REQ-029 The bench SHALL hold out_ready=0 for 5 cycles after out_valid and check that out_data and the flags stay stable and in_ready stays 0; then it SHALL pulse out_ready and check that in_ready=1 on the next cycle.
REQ-030 The bench SHALL assert rst_n=0 at cycle t+10 of a 2.0 operation and check all reset values on the next cycle; it SHALL then submit 4.0 and check 0x40000000 at t+27.
REQ-031 The bench SHALL apply back-to-back in_valid=1 with random operands and out_ready randomized, and check every result against a reference model (round-to-nearest-even, flush-to-zero), both at default parameters and at EXP_W=5, MAN_W=10.
